// File: rtl/des_key_schedule.sv
// DES key schedule: rotates the PC-1 halves per round and serialises PC-2
// through a registered ROM, presenting one 48-bit round key per handshake.
module des_key_schedule #(
  parameter int unsigned ROUNDS = 16
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        ap_start,
  output logic        ap_idle,
  output logic        ap_ready,
  output logic        ap_done,
  input  logic [27:0] C,
  input  logic [27:0] D,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [47:0] key_out,
  output logic [3:0]  key_round
);

  localparam int unsigned HALF_W = 28;
  localparam int unsigned KEY_W  = 48;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned RND_W  = 4;
  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] CD_W       = CNT_W'(2 * HALF_W);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PERM, S_OUT} state_t;

  state_t            r_state;
  logic [HALF_W-1:0] r_c;
  logic [HALF_W-1:0] r_d;
  logic [KEY_W-1:0]  r_acc;
  logic [KEY_W-1:0]  r_key_out;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  r_rom_q;
  logic [RND_W-1:0]  r_round;
  logic              r_idle;
  logic              r_done;
  logic              r_key_valid;

  logic                w_single;
  logic [CNT_W-1:0]    w_rom_addr;
  logic [2*HALF_W-1:0] w_cd;
  logic [CNT_W-1:0]    w_sel;
  logic                w_bit;

  // PC-2 table, FIPS 46-3 order; entry value p selects bit (56 - p) of {C,D}
  function automatic logic [CNT_W-1:0] pc2_rom(input logic [CNT_W-1:0] addr);
    case (addr)
      6'd0:  return 6'd14;  6'd1:  return 6'd17;  6'd2:  return 6'd11;
      6'd3:  return 6'd24;  6'd4:  return 6'd1;   6'd5:  return 6'd5;
      6'd6:  return 6'd3;   6'd7:  return 6'd28;  6'd8:  return 6'd15;
      6'd9:  return 6'd6;   6'd10: return 6'd21;  6'd11: return 6'd10;
      6'd12: return 6'd23;  6'd13: return 6'd19;  6'd14: return 6'd12;
      6'd15: return 6'd4;   6'd16: return 6'd26;  6'd17: return 6'd8;
      6'd18: return 6'd16;  6'd19: return 6'd7;   6'd20: return 6'd27;
      6'd21: return 6'd20;  6'd22: return 6'd13;  6'd23: return 6'd2;
      6'd24: return 6'd41;  6'd25: return 6'd52;  6'd26: return 6'd31;
      6'd27: return 6'd37;  6'd28: return 6'd47;  6'd29: return 6'd55;
      6'd30: return 6'd30;  6'd31: return 6'd40;  6'd32: return 6'd51;
      6'd33: return 6'd45;  6'd34: return 6'd33;  6'd35: return 6'd48;
      6'd36: return 6'd44;  6'd37: return 6'd49;  6'd38: return 6'd39;
      6'd39: return 6'd56;  6'd40: return 6'd34;  6'd41: return 6'd53;
      6'd42: return 6'd46;  6'd43: return 6'd42;  6'd44: return 6'd50;
      6'd45: return 6'd36;  6'd46: return 6'd29;  6'd47: return 6'd32;
      default: return 6'd0;
    endcase
  endfunction

  assign w_single   = (r_round == 4'd0) || (r_round == 4'd1) ||
                      (r_round == 4'd8) || (r_round == 4'd15);
  // ROM address runs one entry ahead so the registered read lines up with PERM
  assign w_rom_addr = (r_state == S_PERM) ? r_bit_cnt + 6'd1 : 6'd0;
  assign w_cd       = {r_c, r_d};
  assign w_sel      = CD_W - r_rom_q;
  assign w_bit      = w_cd[w_sel];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rom_q <= '0;
    end else begin
      r_rom_q <= pc2_rom(w_rom_addr);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state     <= S_IDLE;
      r_c         <= '0;
      r_d         <= '0;
      r_acc       <= '0;
      r_key_out   <= '0;
      r_bit_cnt   <= '0;
      r_round     <= '0;
      r_idle      <= 1'b1;
      r_done      <= 1'b0;
      r_key_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_c     <= C;
            r_d     <= D;
            r_round <= '0;
            r_idle  <= 1'b0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_c       <= w_single ? {r_c[26:0], r_c[27]} : {r_c[25:0], r_c[27:26]};
          r_d       <= w_single ? {r_d[26:0], r_d[27]} : {r_d[25:0], r_d[27:26]};
          r_acc     <= '0;
          r_bit_cnt <= '0;
          r_state   <= S_PERM;
        end
        S_PERM: begin
          r_acc     <= {r_acc[KEY_W-2:0], w_bit};
          r_bit_cnt <= r_bit_cnt + 6'd1;
          if (r_bit_cnt == LAST_BIT) begin
            r_key_out   <= {r_acc[KEY_W-2:0], w_bit};
            r_key_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (key_ready) begin
            r_key_valid <= 1'b0;
            if (r_round == LAST_ROUND) begin
              r_done  <= 1'b1;
              r_idle  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_round <= r_round + 4'd1;
              r_state <= S_SHIFT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ap_ready marks the accepting IDLE cycle itself, so it follows ap_start directly
  assign ap_ready  = ap_rst_n && ap_start && (r_state == S_IDLE);
  assign ap_idle   = r_idle;
  assign ap_done   = r_done;
  assign key_valid = r_key_valid;
  assign key_out   = r_key_out;
  assign key_round = r_round;

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: random and FIPS key pairs checked against a
// direct DES subkey model, plus backpressure, start-while-busy, reset abort and ROUNDS=2.
module tb_des_key_schedule;

  localparam logic [27:0] FIPS_C = 28'hF0CCAAF;
  localparam logic [27:0] FIPS_D = 28'h556678F;
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                              23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  logic        ap_clk;
  logic        ap_rst_n;
  logic        ap_start;
  logic [27:0] C;
  logic [27:0] D;
  logic        key_ready;
  logic        ap_idle, ap_ready, ap_done, key_valid;
  logic [47:0] key_out;
  logic [3:0]  key_round;
  logic        u2_idle, u2_ready, u2_done, u2_kv;
  logic [47:0] u2_ko;
  logic [3:0]  u2_kr;

  int n_total = 0;
  int n_bad   = 0;
  int n_ready_seen = 0;
  int n_done_seen  = 0;

  des_key_schedule dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done),
    .C(C), .D(D), .key_valid(key_valid), .key_ready(key_ready),
    .key_out(key_out), .key_round(key_round)
  );

  des_key_schedule #(.ROUNDS(2)) u2 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_idle(u2_idle), .ap_ready(u2_ready), .ap_done(u2_done),
    .C(C), .D(D), .key_valid(u2_kv), .key_ready(key_ready),
    .key_out(u2_ko), .key_round(u2_kr)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(negedge ap_clk) begin
    if (ap_ready) n_ready_seen++;
    if (ap_done)  n_done_seen++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Subkey r straight from the DES definition: cumulative rotation then PC-2
  function automatic logic [47:0] ref_key(input logic [27:0] c, input logic [27:0] d, input int r);
    int s;
    logic [55:0] tc, td, cd;
    logic [47:0] k;
    s = 0;
    for (int i = 0; i <= r; i++) s += SHIFTS[i];
    s = s % 28;
    tc = {28'b0, c} << s;
    td = {28'b0, d} << s;
    cd = {tc[27:0] | tc[55:28], td[27:0] | td[55:28]};
    for (int i = 0; i < 48; i++) k[47 - i] = cd[56 - PC2[i]];
    return k;
  endfunction

  task automatic run_sched(input logic [27:0] c, input logic [27:0] d, input int bp,
                           input bit poke, input int abort_round);
    int cyc;
    int rdy0, dn0;
    logic [47:0] exp_k;
    rdy0 = n_ready_seen;
    dn0  = n_done_seen;
    @(posedge ap_clk); #1;
    C = c; D = d; ap_start = 1'b1; key_ready = (bp == 0);
    @(negedge ap_clk);
    check_eq("start_ready", 64'(ap_ready), 64'd1);
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    C = 28'($urandom); D = 28'($urandom);
    check_eq("busy_not_idle", 64'(ap_idle), 64'd0);
    for (int r = 0; r < 16; r++) begin
      exp_k = ref_key(c, d, r);
      cyc = 0;
      while (cyc < 200) begin
        @(negedge ap_clk);
        cyc++;
        if (bp > 0) key_ready = 1'b0;
        if (poke && r == 3) begin
          if (cyc == 20) begin
            ap_start = 1'b1; C = 28'($urandom); D = 28'($urandom);
          end else if (cyc == 21) begin
            ap_start = 1'b0;
          end
        end
        if (abort_round == r && cyc == 25) begin
          ap_rst_n = 1'b0;
          #1;
          check_eq("abort_idle", 64'(ap_idle), 64'd1);
          check_eq("abort_outs", 64'({ap_ready, ap_done, key_valid, key_round, key_out}), 64'd0);
          repeat (3) @(negedge ap_clk);
          ap_rst_n = 1'b1;
          check_eq("abort_no_done", 64'(n_done_seen - dn0), 64'd0);
          return;
        end
        if (key_valid) break;
      end
      check_eq("key_latency", 64'(cyc), 64'd50);
      check_eq("key_round", 64'(key_round), 64'(r));
      check_eq("key_out", 64'(key_out), 64'(exp_k));
      if (c == FIPS_C && d == FIPS_D && r == 0)  check_eq("fips_k1", 64'(key_out), 64'h1B02EFFC7072);
      if (c == FIPS_C && d == FIPS_D && r == 15) check_eq("fips_k16", 64'(key_out), 64'hCB3D8B0E17F5);
      if (bp > 0) begin
        repeat (bp) begin
          @(negedge ap_clk);
          check_eq("hold_stable", 64'({key_valid, key_round, key_out}), 64'({1'b1, 4'(r), exp_k}));
        end
        key_ready = 1'b1;
      end
    end
    cyc = 0;
    while (cyc < 5) begin
      @(negedge ap_clk);
      cyc++;
      if (ap_done) break;
    end
    check_eq("done_timing", 64'(cyc), 64'd1);
    repeat (3) @(negedge ap_clk);
    check_eq("done_once", 64'(n_done_seen - dn0), 64'd1);
    check_eq("ready_once", 64'(n_ready_seen - rdy0), 64'd1);
    check_eq("end_idle", 64'({ap_idle, key_valid}), 64'b10);
  endtask

  initial begin
    logic [27:0] c2, d2;
    int got, dn;
    ap_rst_n = 1'b0; ap_start = 1'b1; key_ready = 1'b0; C = '0; D = '0;
    repeat (3) @(negedge ap_clk);
    check_eq("rst_ready", 64'(ap_ready), 64'd0);
    check_eq("rst_idle", 64'(ap_idle), 64'd1);
    check_eq("rst_outs", 64'({ap_done, key_valid, key_round, key_out}), 64'd0);
    ap_start = 1'b0;
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);

    run_sched(FIPS_C, FIPS_D, 0, 1'b0, -1);
    run_sched(FIPS_C, FIPS_D, 10, 1'b0, -1);
    run_sched(28'h0, 28'h0, 0, 1'b0, -1);
    run_sched(28'hFFFFFFF, 28'hFFFFFFF, 0, 1'b0, -1);
    run_sched(FIPS_C, FIPS_D, 0, 1'b1, -1);
    for (int t = 0; t < 3; t++)
      run_sched(28'($urandom), 28'($urandom), int'($urandom_range(0, 3)), 1'b0, -1);
    run_sched(FIPS_C, FIPS_D, 0, 1'b0, 5);
    run_sched(FIPS_C, FIPS_D, 0, 1'b0, -1);

    // ROUNDS=2 instance from a clean reset
    ap_rst_n = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    key_ready = 1'b1;
    c2 = 28'($urandom); d2 = 28'($urandom);
    @(posedge ap_clk); #1;
    C = c2; D = d2; ap_start = 1'b1;
    @(negedge ap_clk);
    check_eq("r2_ready", 64'(u2_ready), 64'd1);
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    got = 0; dn = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge ap_clk);
      if (u2_kv) begin
        check_eq("r2_round", 64'(u2_kr), 64'(got));
        check_eq("r2_key", 64'(u2_ko), 64'(ref_key(c2, d2, got)));
        got++;
      end
      if (u2_done) dn++;
    end
    check_eq("r2_key_count", 64'(got), 64'd2);
    check_eq("r2_done_count", 64'(dn), 64'd1);
    check_eq("r2_idle", 64'(u2_idle), 64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
